hub75_receiver: RTL and testbench

HUB75_RECEIVER -- requirements
Module: hub75_receiver

---
 rtl/hub75_pkg.sv | 21 ++
 rtl/hub75_sync.sv | 36 +++
 rtl/hub75_receiver.sv | 186 ++++++++++++++++++
 tb/tb_hub75_receiver.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants and types for the HUB75 panel receiver and its
// driver. Holds the default row width, the ON_TIME counter width, the
// synchronized input vector layout and the row holding-buffer state enum.
package hub75_pkg;

  localparam int unsigned HUB75_WIDTH = 32;
  localparam int unsigned ON_TIME_W   = 16;

  // Layout of the synchronized panel input vector.
  localparam int unsigned N_SYNC    = 13;
  localparam int unsigned IDX_ADDR  = 6;   // [9:6] = RD..RA
  localparam int unsigned IDX_PCLK  = 10;
  localparam int unsigned IDX_LATCH = 11;
  localparam int unsigned IDX_OE_N  = 12;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/hub75_sync.sv
// hub75_sync: N-bit multi-flop synchronizer, every bit with identical delay.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears all stages
//   d_i    : asynchronous inputs
//   q_o    : synchronized outputs, STAGES clock cycles later
module hub75_sync #(
  parameter int unsigned N      = 13,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] stage_q [STAGES];
  logic [N-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/hub75_receiver.sv
// hub75_receiver: captures HUB75 panel rows (two banks x RGB serial data)
// into a single-entry holding buffer with a valid/ready handshake.
//   CLK_I, RST_NI          : system clock (>= 8x PCLK_I), async active-low reset
//   R0_I..B1_I             : serial colour data, top (0) and bottom (1) bank
//   RA_I..RD_I             : row address, RA_I is the LSB
//   PCLK_I, LATCH_I, OE_NI : panel shift clock, row latch, output enable (low)
//   ROW_VALID_O/READY_I    : row handshake
//   ROW_ADDR_O, *_O data   : captured row, bit k = k-th bit received
//   BITCNT_ERR_O           : captured row did not hold exactly WIDTH bits
//   ON_TIME_O              : OE_NI-low cycles between previous latch and this one
//   OVF_O / OVF_CLR_I      : sticky dropped-row flag and its synchronous clear
module hub75_receiver
  import hub75_pkg::*;
#(
  parameter int unsigned WIDTH       = HUB75_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 R0_I,
  input  logic                 G0_I,
  input  logic                 B0_I,
  input  logic                 R1_I,
  input  logic                 G1_I,
  input  logic                 B1_I,
  input  logic                 RA_I,
  input  logic                 RB_I,
  input  logic                 RC_I,
  input  logic                 RD_I,
  input  logic                 PCLK_I,
  input  logic                 LATCH_I,
  input  logic                 OE_NI,
  output logic                 ROW_VALID_O,
  input  logic                 ROW_READY_I,
  output logic [3:0]           ROW_ADDR_O,
  output logic [WIDTH-1:0]     RED0_O,
  output logic [WIDTH-1:0]     GREEN0_O,
  output logic [WIDTH-1:0]     BLUE0_O,
  output logic [WIDTH-1:0]     RED1_O,
  output logic [WIDTH-1:0]     GREEN1_O,
  output logic [WIDTH-1:0]     BLUE1_O,
  output logic                 BITCNT_ERR_O,
  output logic [ON_TIME_W-1:0] ON_TIME_O,
  output logic                 OVF_O,
  input  logic                 OVF_CLR_I
);

  localparam int unsigned      CNT_W   = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ROW = CNT_W'(WIDTH);

  logic [N_SYNC-1:0] in_raw, in_sync;

  assign in_raw = {OE_NI, LATCH_I, PCLK_I, RD_I, RC_I, RB_I, RA_I,
                   B1_I, G1_I, R1_I, B0_I, G0_I, R0_I};

  hub75_sync #(.N(N_SYNC), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i (CLK_I),
    .rst_ni(RST_NI),
    .d_i   (in_raw),
    .q_o   (in_sync)
  );

  // Edge-detect stage: edge pulses and the data/address/OE sampled with them.
  logic [1:0]           edge_prev_q, edge_prev_d;
  logic                 pclk_ev_q, pclk_ev_d;
  logic                 latch_ev_q, latch_ev_d;
  logic [5:0]           bits_ev_q, bits_ev_d;
  logic [3:0]           addr_ev_q, addr_ev_d;
  logic                 oe_n_ev_q, oe_n_ev_d;
  // Capture runs one cycle after the latch edge so a coincident shift lands first.
  logic                 cap_q, cap_d;

  logic [WIDTH-1:0]     shreg_q [6];
  logic [WIDTH-1:0]     shreg_d [6];
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ON_TIME_W-1:0] on_cnt_q, on_cnt_d;

  buf_state_e           state_q, state_d;
  logic [WIDTH-1:0]     hold_q [6];
  logic [WIDTH-1:0]     hold_d [6];
  logic [3:0]           hold_addr_q, hold_addr_d;
  logic                 hold_err_q, hold_err_d;
  logic [ON_TIME_W-1:0] hold_on_q, hold_on_d;
  logic                 ovf_q, ovf_d;
  logic                 xfer, drop;

  always_comb begin
    edge_prev_d = {in_sync[IDX_LATCH], in_sync[IDX_PCLK]};
    pclk_ev_d   = in_sync[IDX_PCLK]  & ~edge_prev_q[0];
    latch_ev_d  = in_sync[IDX_LATCH] & ~edge_prev_q[1];
    bits_ev_d   = in_sync[5:0];
    addr_ev_d   = in_sync[IDX_ADDR +: 4];
    oe_n_ev_d   = in_sync[IDX_OE_N];
    cap_d       = latch_ev_q;

    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    on_cnt_d    = on_cnt_q;
    state_d     = state_q;
    hold_d      = hold_q;
    hold_addr_d = hold_addr_q;
    hold_err_d  = hold_err_q;
    hold_on_d   = hold_on_q;
    drop        = 1'b0;

    if (pclk_ev_q) begin
      for (int unsigned c = 0; c < 6; c++) begin
        shreg_d[c] = {bits_ev_q[c], shreg_q[c][WIDTH-1:1]};
      end
      if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (!oe_n_ev_q && (on_cnt_q != '1)) on_cnt_d = on_cnt_q + 1'b1;

    xfer = (state_q == BUF_FULL) && ROW_READY_I;
    if (xfer) state_d = BUF_EMPTY;

    if (cap_q) begin
      if ((state_q == BUF_EMPTY) || xfer) begin
        state_d     = BUF_FULL;
        hold_d      = shreg_q;
        hold_addr_d = addr_ev_q;
        hold_err_d  = (bit_cnt_q != CNT_ROW);
        hold_on_d   = on_cnt_q;
      end else begin
        drop = 1'b1;
      end
      bit_cnt_d = pclk_ev_q ? CNT_W'(1) : '0;
      on_cnt_d  = '0;
    end

    ovf_d = (ovf_q & ~OVF_CLR_I) | drop;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      edge_prev_q <= '0;
      pclk_ev_q   <= 1'b0;
      latch_ev_q  <= 1'b0;
      bits_ev_q   <= '0;
      addr_ev_q   <= '0;
      oe_n_ev_q   <= 1'b0;
      cap_q       <= 1'b0;
      shreg_q     <= '{default: '0};
      bit_cnt_q   <= '0;
      on_cnt_q    <= '0;
      state_q     <= BUF_EMPTY;
      hold_q      <= '{default: '0};
      hold_addr_q <= '0;
      hold_err_q  <= 1'b0;
      hold_on_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      edge_prev_q <= edge_prev_d;
      pclk_ev_q   <= pclk_ev_d;
      latch_ev_q  <= latch_ev_d;
      bits_ev_q   <= bits_ev_d;
      addr_ev_q   <= addr_ev_d;
      oe_n_ev_q   <= oe_n_ev_d;
      cap_q       <= cap_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      on_cnt_q    <= on_cnt_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
      hold_err_q  <= hold_err_d;
      hold_on_q   <= hold_on_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ROW_VALID_O  = (state_q == BUF_FULL);
  assign ROW_ADDR_O   = hold_addr_q;
  assign RED0_O       = hold_q[0];
  assign GREEN0_O     = hold_q[1];
  assign BLUE0_O      = hold_q[2];
  assign RED1_O       = hold_q[3];
  assign GREEN1_O     = hold_q[4];
  assign BLUE1_O      = hold_q[5];
  assign BITCNT_ERR_O = hold_err_q;
  assign ON_TIME_O    = hold_on_q;
  assign OVF_O        = ovf_q;

endmodule

// File: tb/tb_hub75_receiver.sv
module tb_hub75_receiver;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 2;
  localparam int unsigned RW = 6 * W + 5;

  logic CLK_I = 1'b0;
  logic RST_NI = 1'b0;
  logic R0_I = 0, G0_I = 0, B0_I = 0, R1_I = 0, G1_I = 0, B1_I = 0;
  logic RA_I = 0, RB_I = 0, RC_I = 0, RD_I = 0;
  logic PCLK_I = 0, LATCH_I = 0, OE_NI = 1;
  logic ROW_READY_I = 0, OVF_CLR_I = 0;
  logic ROW_VALID_O, BITCNT_ERR_O, OVF_O;
  logic [3:0]  ROW_ADDR_O;
  logic [W-1:0] RED0_O, GREEN0_O, BLUE0_O, RED1_O, GREEN1_O, BLUE1_O;
  logic [15:0] ON_TIME_O;
  logic [RW-1:0] dut_row;

  hub75_receiver #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI),
    .R0_I(R0_I), .G0_I(G0_I), .B0_I(B0_I), .R1_I(R1_I), .G1_I(G1_I), .B1_I(B1_I),
    .RA_I(RA_I), .RB_I(RB_I), .RC_I(RC_I), .RD_I(RD_I),
    .PCLK_I(PCLK_I), .LATCH_I(LATCH_I), .OE_NI(OE_NI),
    .ROW_VALID_O(ROW_VALID_O), .ROW_READY_I(ROW_READY_I), .ROW_ADDR_O(ROW_ADDR_O),
    .RED0_O(RED0_O), .GREEN0_O(GREEN0_O), .BLUE0_O(BLUE0_O),
    .RED1_O(RED1_O), .GREEN1_O(GREEN1_O), .BLUE1_O(BLUE1_O),
    .BITCNT_ERR_O(BITCNT_ERR_O), .ON_TIME_O(ON_TIME_O),
    .OVF_O(OVF_O), .OVF_CLR_I(OVF_CLR_I)
  );

  always #5 CLK_I = ~CLK_I;

  assign dut_row = {RED0_O, GREEN0_O, BLUE0_O, RED1_O, GREEN1_O, BLUE1_O,
                    ROW_ADDR_O, BITCNT_ERR_O};

  int total = 0;
  int bad   = 0;

  // Reference model: every bit ever clocked in (index 0=R0,1=G0,2=B0,3=R1,4=G1,5=B1).
  // A captured row is simply the last W bits received, oldest at bit 0.
  logic [5:0] hist[$];
  logic [5:0] pat[$];
  int  ot_cnt   = 0;
  bit  ot_known = 0;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < int'(W); i++) hist.push_back(6'd0);
    ot_cnt   = 0;
    ot_known = 0;
  endfunction

  function automatic logic [RW-1:0] exp_row(logic [3:0] addr, logic err);
    logic [W-1:0] v [6];
    int base;
    base = hist.size() - int'(W);
    for (int c = 0; c < 6; c++)
      for (int p = 0; p < int'(W); p++) v[c][p] = hist[base + p][c];
    return {v[0], v[1], v[2], v[3], v[4], v[5], addr, err};
  endfunction

  function automatic void note_latch(output logic [15:0] exp_on, output bit known);
    known    = ot_known;
    exp_on   = (ot_cnt > 65535) ? 16'hFFFF : 16'(ot_cnt);
    ot_cnt   = 0;
    ot_known = 1;
  endfunction

  function automatic void fill_random(int n);
    pat.delete();
    for (int i = 0; i < n; i++) pat.push_back(6'($urandom));
  endfunction

  task automatic shift_bits(input logic [3:0] addr, input bit coincide);
    int n;
    n = pat.size();
    @(negedge CLK_I);
    {RD_I, RC_I, RB_I, RA_I} = addr;
    for (int i = 0; i < n; i++) begin
      PCLK_I = 0;
      {B1_I, G1_I, R1_I, B0_I, G0_I, R0_I} = pat[i];
      repeat (4) @(negedge CLK_I);
      PCLK_I = 1;
      hist.push_back(pat[i]);
      if (coincide && i == n - 1) LATCH_I = 1;
      else repeat (4) @(negedge CLK_I);
    end
    pat.delete();
    if (!coincide) begin
      PCLK_I = 0;
      repeat (3) @(negedge CLK_I);
    end
  endtask

  // Starts on a negedge; capture happens on the 5th posedge after LATCH_I rises.
  task automatic do_latch(input bit already_high, input bit clr_at_cap);
    LATCH_I = 1;
    repeat (4) @(negedge CLK_I);
    if (clr_at_cap) OVF_CLR_I = 1;
    @(negedge CLK_I);
    OVF_CLR_I = 0;
    LATCH_I   = 0;
    PCLK_I    = 0;
    repeat (4) @(negedge CLK_I);
    if (already_high) begin end
  endtask

  task automatic oe_low(input int n);
    @(negedge CLK_I);
    OE_NI = 0;
    repeat (n) @(negedge CLK_I);
    OE_NI = 1;
    ot_cnt += n;
  endtask

  task automatic accept();
    @(negedge CLK_I);
    ROW_READY_I = 1;
    @(negedge CLK_I);
    ROW_READY_I = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK_I);
    RST_NI = 0;
    PCLK_I = 0; LATCH_I = 0; OE_NI = 1; ROW_READY_I = 0; OVF_CLR_I = 0;
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK_I);
    total++;
    if (dut_row !== '0) begin bad++; $display("FAIL reset_row: got %h want 0", dut_row); end
    total++;
    if ({ROW_VALID_O, OVF_O} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {ROW_VALID_O, OVF_O}); end
    total++;
    if (ON_TIME_O !== 16'h0) begin bad++; $display("FAIL reset_on_time: got %h want 0", ON_TIME_O); end
    RST_NI = 1;
    model_reset();
    repeat (4) @(negedge CLK_I);
  endtask

  task automatic test_basic();
    logic [31:0] r0, r1;
    logic [15:0] eon;
    bit kn;
    int n;
    logic [RW-1:0] e;
    r0 = 32'hAAAAAAAA;
    r1 = 32'h55555555;
    pat.delete();
    for (int i = 0; i < 32; i++) begin
      logic [5:0] b;
      b = 6'($urandom);
      b[0] = r0[i];
      b[3] = r1[i];
      pat.push_back(b);
    end
    shift_bits(4'hF, 0);
    LATCH_I = 1;
    @(posedge CLK_I);
    #1;
    n = 0;
    while (!ROW_VALID_O && n < 20) begin
      @(posedge CLK_I);
      #1;
      n++;
    end
    total++;
    if (n !== int'(S) + 2) begin bad++; $display("FAIL valid_latency: got %0d want %0d", n, S + 2); end
    @(negedge CLK_I);
    LATCH_I = 0;
    repeat (4) @(negedge CLK_I);
    note_latch(eon, kn);
    e = exp_row(4'hF, 1'b0);
    total++;
    if (dut_row !== e) begin bad++; $display("FAIL basic_row: got %h want %h", dut_row, e); end
    total++;
    if ({RED0_O, RED1_O, ROW_ADDR_O, BITCNT_ERR_O} !== {32'hAAAAAAAA, 32'h55555555, 4'hF, 1'b0}) begin
      bad++; $display("FAIL basic_fixed: got %h %h %h %b", RED0_O, RED1_O, ROW_ADDR_O, BITCNT_ERR_O);
    end
    accept();
    total++;
    if (ROW_VALID_O !== 1'b0) begin bad++; $display("FAIL basic_accept: valid got %b want 0", ROW_VALID_O); end
  endtask

  task automatic test_bitcnt();
    logic [15:0] eon;
    bit kn;
    logic [RW-1:0] e;
    fill_random(31);
    shift_bits(4'h3, 0);
    do_latch(0, 0);
    note_latch(eon, kn);
    e = exp_row(4'h3, 1'b1);
    total++;
    if (dut_row !== e) begin bad++; $display("FAIL bitcnt_31: got %h want %h", dut_row, e); end
    accept();
    fill_random(32);
    shift_bits(4'h4, 0);
    do_latch(0, 0);
    note_latch(eon, kn);
    e = exp_row(4'h4, 1'b0);
    total++;
    if (dut_row !== e) begin bad++; $display("FAIL bitcnt_32: got %h want %h", dut_row, e); end
    accept();
  endtask

  task automatic test_coincide();
    logic [15:0] eon;
    bit kn;
    logic [RW-1:0] e;
    fill_random(32);
    shift_bits(4'hA, 1);
    do_latch(1, 0);
    note_latch(eon, kn);
    e = exp_row(4'hA, 1'b0);
    total++;
    if (dut_row !== e) begin bad++; $display("FAIL coincide_row: got %h want %h", dut_row, e); end
    accept();
  endtask

  task automatic test_on_time();
    logic [15:0] eon;
    bit kn;
    int lens [2];
    lens[0] = 100;
    lens[1] = 66000;
    for (int k = 0; k < 2; k++) begin
      oe_low(lens[k]);
      fill_random(32);
      shift_bits(4'(k + 1), 0);
      do_latch(0, 0);
      note_latch(eon, kn);
      total++;
      if (!kn || ON_TIME_O !== eon) begin
        bad++; $display("FAIL on_time_%0d: got %h want %h (known=%0d)", lens[k], ON_TIME_O, eon, kn);
      end
      accept();
    end
  endtask

  task automatic test_overflow();
    logic [15:0] eon;
    bit kn;
    logic [RW-1:0] ea;
    fill_random(32);
    shift_bits(4'h6, 0);
    do_latch(0, 0);
    note_latch(eon, kn);
    ea = exp_row(4'h6, 1'b0);
    fill_random(32);
    shift_bits(4'h9, 0);
    do_latch(0, 0);
    note_latch(eon, kn);
    total++;
    if (dut_row !== ea) begin bad++; $display("FAIL ovf_keep_old: got %h want %h", dut_row, ea); end
    total++;
    if ({ROW_VALID_O, OVF_O} !== 2'b11) begin bad++; $display("FAIL ovf_set: got %b want 11", {ROW_VALID_O, OVF_O}); end
    fill_random(32);
    shift_bits(4'hC, 0);
    do_latch(0, 1);
    note_latch(eon, kn);
    total++;
    if (OVF_O !== 1'b1) begin bad++; $display("FAIL ovf_clr_vs_set: got %b want 1", OVF_O); end
    @(negedge CLK_I);
    OVF_CLR_I = 1;
    @(negedge CLK_I);
    OVF_CLR_I = 0;
    total++;
    if (OVF_O !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", OVF_O); end
    total++;
    if (dut_row !== ea) begin bad++; $display("FAIL ovf_hold: got %h want %h", dut_row, ea); end
    accept();
    total++;
    if (ROW_VALID_O !== 1'b0) begin bad++; $display("FAIL ovf_drain: valid got %b want 0", ROW_VALID_O); end
  endtask

  task automatic test_random_rows();
    logic [15:0] eon;
    bit kn;
    logic [RW-1:0] e;
    logic [3:0] a;
    int n;
    for (int r = 0; r < 6; r++) begin
      oe_low(int'($urandom_range(1, 300)));
      case ($urandom_range(0, 3))
        0: n = W - 1;
        1: n = W;
        2: n = W + 1;
        default: n = int'($urandom_range(20, 44));
      endcase
      a = 4'($urandom);
      fill_random(n);
      shift_bits(a, 0);
      do_latch(0, 0);
      note_latch(eon, kn);
      e = exp_row(a, (n != int'(W)));
      total++;
      if (dut_row !== e) begin bad++; $display("FAIL rand_row%0d n=%0d: got %h want %h", r, n, dut_row, e); end
      total++;
      if (!kn || ON_TIME_O !== eon) begin bad++; $display("FAIL rand_on%0d: got %h want %h", r, ON_TIME_O, eon); end
      repeat ($urandom_range(0, 5)) @(negedge CLK_I);
      total++;
      if (ROW_VALID_O !== 1'b1 || dut_row !== e) begin bad++; $display("FAIL rand_stable%0d: valid %b row %h", r, ROW_VALID_O, dut_row); end
      accept();
      total++;
      if (ROW_VALID_O !== 1'b0) begin bad++; $display("FAIL rand_accept%0d: valid got %b want 0", r, ROW_VALID_O); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] eon;
    bit kn;
    logic [RW-1:0] e;
    fill_random(32);
    shift_bits(4'h7, 0);
    do_latch(0, 0);
    note_latch(eon, kn);
    fill_random(10);
    shift_bits(4'h2, 0);
    do_reset();
    total++;
    if (dut_row !== '0 || ROW_VALID_O !== 1'b0 || OVF_O !== 1'b0) begin
      bad++; $display("FAIL midreset_clear: row %h valid %b ovf %b want all 0", dut_row, ROW_VALID_O, OVF_O);
    end
    RST_NI = 1;
    model_reset();
    repeat (20) @(negedge CLK_I);
    total++;
    if (ROW_VALID_O !== 1'b0) begin bad++; $display("FAIL midreset_stale: valid got %b want 0", ROW_VALID_O); end
    fill_random(32);
    shift_bits(4'h5, 0);
    do_latch(0, 0);
    note_latch(eon, kn);
    e = exp_row(4'h5, 1'b0);
    total++;
    if (ROW_VALID_O !== 1'b1 || dut_row !== e) begin
      bad++; $display("FAIL midreset_row: valid %b got %h want %h", ROW_VALID_O, dut_row, e);
    end
    accept();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bitcnt();
    test_coincide();
    test_on_time();
    test_overflow();
    test_random_rows();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
